// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port RAM, with a bounded lock hold.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin tie-break (default: fixed m0 priority).
module mem_arbiter #(
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_lock,
  input  logic        m1_lock,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wd,
  input  logic [31:0] m1_wd,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic [31:0] rdata,
  input  logic [31:0] mem_rd,
  output logic        memwrite,
  output logic [31:0] addr,
  output logic [31:0] wd
);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_e;

  localparam logic [7:0] CNT_LAST = 8'(LOCK_MAX - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       hold;
  logic       prefer1;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic       last1_q, last1_d;
`endif

  function automatic state_e arb(input logic r0, input logic r1, input logic p1);
    if (r0 && r1) return p1 ? BUSY1 : BUSY0;
    if (r0)       return BUSY0;
    if (r1)       return BUSY1;
    return IDLE;
  endfunction

  always_comb begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    prefer1 = ~last1_q;
`else
    prefer1 = 1'b0;
`endif
    hold = 1'b0;
    // A lock expiring at the limit hands over to the other master if it is waiting.
    case (state_q)
      BUSY0: begin
        hold = m0_req && m0_lock && (cnt_q < CNT_LAST);
        if (m0_req && m0_lock && !hold) prefer1 = 1'b1;
      end
      BUSY1: begin
        hold = m1_req && m1_lock && (cnt_q < CNT_LAST);
        if (m1_req && m1_lock && !hold) prefer1 = 1'b0;
      end
      default: ;
    endcase
    state_d = hold ? state_q : arb(m0_req, m1_req, prefer1);
    cnt_d   = hold ? cnt_q + 8'd1 : '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    last1_d = last1_q;
    if (state_d == BUSY1)      last1_d = 1'b1;
    else if (state_d == BUSY0) last1_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last1_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last1_q <= last1_d;
`endif
    end
  end

  always_comb begin
    m0_gnt   = (state_q == BUSY0) && m0_req;
    m1_gnt   = (state_q == BUSY1) && m1_req;
    memwrite = 1'b0;
    addr     = '0;
    wd       = '0;
    case (state_q)
      BUSY0: begin
        addr     = m0_addr;
        wd       = m0_wd;
        memwrite = m0_we && m0_req;
      end
      BUSY1: begin
        addr     = m1_addr;
        wd       = m1_wd;
        memwrite = m1_we && m1_req;
      end
      default: ;
    endcase
  end

  assign rdata = mem_rd;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter LOCK_MAX, default 8, meaning the maximum consecutive grant cycles one master may hold under lock (legal range 1..255).
REQ-002 The block SHALL have clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have reset  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have m0_req, m1_req  input  1 each  access request; m0 is the ktc32 core, m1 is the loader/DMA.
REQ-005 The block SHALL have m0_lock, m1_lock  input  1 each  request to keep the grant for the following cycle.
REQ-006 The block SHALL have m0_we, m1_we  input  1 each  write enable of the request.
REQ-007 The block SHALL have m0_addr, m1_addr, m0_wd, m1_wd  input  32 each  address and write data.
REQ-008 The block SHALL have m0_gnt, m1_gnt  output  1 each  access performed this cycle.
REQ-009 The block SHALL have rdata  output  32  read data, equal to mem_rd.
REQ-010 The block SHALL have mem_rd  input  32  combinational RAM read data.
REQ-011 The block SHALL have memwrite  output  1  RAM write strobe.
REQ-012 The block SHALL have addr, wd  output  32 each  RAM address and write data.

Function
REQ-013 States SHALL be IDLE, BUSY0 and BUSY1; mx_gnt SHALL be 1 exactly in BUSYx while mx_req=1.
REQ-014 In IDLE, any req SHALL move the FSM to BUSYx at the next edge (1-cycle grant latency); no req keeps IDLE.
REQ-015 In BUSYx, addr/wd SHALL follow mx_addr/mx_wd combinationally, and memwrite SHALL equal mx_we AND mx_req.
REQ-016 Outside BUSYx, memwrite SHALL be 0, and addr/wd SHALL be 0.
REQ-017 Masters SHALL hold req/we/addr/wd stable from assertion until the gnt cycle; the write commits on the edge ending the gnt cycle.
REQ-018 A hold counter (8 bits) SHALL clear on entry to BUSYx and increment each BUSYx cycle.
REQ-019 BUSYx SHALL persist while mx_req=1, mx_lock=1 and counter < LOCK_MAX-1.
REQ-020 Otherwise BUSYx SHALL release; the next state is chosen by arbitration among the pending requests without an IDLE bubble, or IDLE when none is pending.
REQ-021 A forced release at LOCK_MAX SHALL re-grant the same master (counter cleared) only if the other master has no request.
REQ-022 mx_req dropping in BUSYx SHALL end the grant that cycle (gnt=0, memwrite=0) and return the FSM to arbitration.
REQ-023 A "last served" bit SHALL update on every entry to BUSYx.

Reset
REQ-024 Reset SHALL immediately force state IDLE, counter 0, last served = m1, all gnt 0, memwrite 0, addr 0 and wd 0, independent of clk.
REQ-025 Reset asserted mid-access SHALL abort that access with no RAM write; after release, the first grant follows REQ-014.

Configuration
REQ-026 With MEM_ARBITER_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the master not last served.
REQ-027 Without MEM_ARBITER_ROUND_ROBIN_EN, m0 SHALL always win simultaneous requests, and the last-served bit SHALL be omitted.

Verification
REQ-028 Single write: m0 req, we=1, addr=84, wd=7 from IDLE -> next cycle m0_gnt=1, memwrite=1, addr=84, and RAM[84]=7 after the edge.
REQ-029 Single read: m1 read of addr=80 holding 0x1234 -> m1_gnt=1 with rdata=0x1234 in the same cycle, and memwrite=0.
REQ-030 Contention: both masters request continuously, no lock, round-robin enabled -> grants alternate m0,m1,m0,m1; without the macro -> m0 every cycle.
REQ-031 Lock limit: m1 lock=1 with LOCK_MAX=4 while m0 is also requesting -> exactly 4 consecutive m1 grants, then m0 granted on the next cycle.
REQ-032 Reset mid-op: reset raised during an m0 write gnt cycle -> memwrite drops before the next edge, the RAM is unchanged, and the FSM is IDLE.
